// File: rtl/aes_trace_seq_pkg.sv
// Shared types and constants for the AES trace-acquisition sequencer.
// Holds the FSM state enum, campaign mode codes and the LFSR polynomial.
package aes_trace_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [1:0] MODE_FIXED  = 2'd0;
    localparam logic [1:0] MODE_RANDOM = 2'd1;
    localparam logic [1:0] MODE_FVR    = 2'd2;

    // x^128 + x^29 + x^27 + x^2 + 1, low-order terms folded back on carry-out
    localparam logic [127:0] LFSR_TAPS    = 128'h2800_0005;
    localparam logic [127:0] DEFAULT_SEED = 128'h1;

    function automatic logic [127:0] lfsr_next(input logic [127:0] s);
        logic [127:0] sh;
        sh = {s[126:0], 1'b0};
        return s[127] ? (sh ^ LFSR_TAPS) : sh;
    endfunction

endpackage

// File: rtl/aes_seq_lfsr128.sv
// 128-bit Galois LFSR used as the plaintext source for random traces.
// Ports: clk_i, rst_ni (async low), ld_i/seed_i reload, step_i advance, state_o.
module aes_seq_lfsr128
    import aes_trace_seq_pkg::*;
#(
    parameter logic [127:0] SEED = DEFAULT_SEED
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         ld_i,
    input  logic [127:0] seed_i,
    input  logic         step_i,
    output logic [127:0] state_o
);

    logic [127:0] state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SEED;
        end else if (ld_i) begin
            state_q <= seed_i;
        end else if (step_i) begin
            state_q <= lfsr_next(state_q);
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/aes_trace_seq.sv
// Stimulus sequencer driving AES_top through fixed / random / fixed-vs-random
// trace campaigns: AES_en windows, idle gaps, scope trigger, ciphertext capture.
// Ports: AES_clk/AES_rst_n, host config (start/abort/mode/num/pt/key),
// AES_top side (en/data_in/key_in, data_out_valid/data_out), status outputs.
// Optional watchdog on RUN enabled by defining AES_SEQ_TIMEOUT_EN.
module aes_trace_seq
    import aes_trace_seq_pkg::*;
#(
    parameter int           DATA_W     = 128,
    parameter int           CNT_W      = 16,
    parameter int           EN_HOLD    = 51,
    parameter int           GAP_CYCLES = 15,
    parameter logic [127:0] LFSR_SEED  = DEFAULT_SEED,
    parameter int           TIMEOUT    = 1024
) (
    input  logic              AES_clk,
    input  logic              AES_rst_n,
    input  logic              AES_start,
    input  logic              AES_abort,
    input  logic [1:0]        AES_mode,
    input  logic [CNT_W-1:0]  AES_num_traces,
    input  logic [DATA_W-1:0] AES_fixed_pt,
    input  logic [DATA_W-1:0] AES_cfg_key,
    output logic              AES_en,
    output logic [DATA_W-1:0] AES_data_in,
    output logic [DATA_W-1:0] AES_key_in,
    input  logic              AES_data_out_valid,
    input  logic [DATA_W-1:0] AES_data_out,
    output logic              AES_trig,
    output logic [DATA_W-1:0] AES_ct_out,
    output logic              AES_ct_valid,
    output logic [CNT_W-1:0]  AES_trace_idx,
    output logic              AES_busy,
    output logic              AES_done,
    output logic              AES_aborted,
    output logic              AES_timeout_err
);

    localparam int HW = $clog2(EN_HOLD + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    // GAP is one cycle short of GAP_CYCLES because LOAD also keeps AES_en low
    if (LFSR_SEED == '0 || TIMEOUT < 1 || EN_HOLD < 1 || GAP_CYCLES < 2)
    begin : g_bad_param
        $error("aes_trace_seq: invalid parameter set");
    end

    state_t            state_q;
    logic              start_q;
    logic [1:0]        mode_q;
    logic [CNT_W-1:0]  num_q;
    logic [DATA_W-1:0] fix_q;
    logic [DATA_W-1:0] key_q;
    logic [CNT_W-1:0]  idx_q;
    logic [HW-1:0]     hold_q;
    logic [GW-1:0]     gap_q;
    logic              seen_q;
    logic              en_q, trig_q, ctv_q, busy_q, done_q, aborted_q;
    logic [DATA_W-1:0] din_q, kin_q, ct_q;
    logic [127:0]      lfsr_state;
    logic [DATA_W-1:0] pt_sel;
    logic              use_rnd;
    logic              lfsr_step;
    logic              hold_done;

`ifdef AES_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd_q;
    logic          tmo_q;
    assign AES_timeout_err = tmo_q;
`else
    assign AES_timeout_err = 1'b0;
`endif

    always_comb begin
        pt_sel  = fix_q;
        use_rnd = 1'b0;
        unique case (mode_q)
            MODE_RANDOM: use_rnd = 1'b1;
            MODE_FVR:    use_rnd = idx_q[0];
            default:     use_rnd = 1'b0;
        endcase
        if (use_rnd) pt_sel = DATA_W'(lfsr_state);
    end

    assign lfsr_step = (state_q == S_LOAD) && !AES_abort && use_rnd;
    assign hold_done = (hold_q == HW'(EN_HOLD - 1));

    aes_seq_lfsr128 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_i   (AES_clk),
        .rst_ni  (AES_rst_n),
        .ld_i    (1'b0),
        .seed_i  (LFSR_SEED),
        .step_i  (lfsr_step),
        .state_o (lfsr_state)
    );

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            mode_q    <= '0;
            num_q     <= '0;
            fix_q     <= '0;
            key_q     <= '0;
            idx_q     <= '0;
            hold_q    <= '0;
            gap_q     <= '0;
            seen_q    <= 1'b0;
            en_q      <= 1'b0;
            trig_q    <= 1'b0;
            ctv_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            din_q     <= '0;
            kin_q     <= '0;
            ct_q      <= '0;
`ifdef AES_SEQ_TIMEOUT_EN
            wd_q      <= '0;
            tmo_q     <= 1'b0;
`endif
        end else begin
            trig_q <= 1'b0;
            ctv_q  <= 1'b0;
            done_q <= 1'b0;
            // start is registered so the FSM acts one cycle after the pulse
            start_q <= AES_start && (state_q == S_IDLE) && !start_q;
            if (AES_start && (state_q == S_IDLE) && !start_q) begin
                mode_q <= AES_mode;
                num_q  <= AES_num_traces;
                fix_q  <= AES_fixed_pt;
                key_q  <= AES_cfg_key;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (start_q) begin
                        aborted_q <= 1'b0;
`ifdef AES_SEQ_TIMEOUT_EN
                        tmo_q     <= 1'b0;
`endif
                        idx_q     <= '0;
                        if (num_q == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (AES_abort) begin
                        en_q      <= 1'b0;
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        din_q   <= pt_sel;
                        kin_q   <= key_q;
                        en_q    <= 1'b1;
                        trig_q  <= 1'b1;
                        hold_q  <= '0;
                        seen_q  <= 1'b0;
`ifdef AES_SEQ_TIMEOUT_EN
                        wd_q    <= '0;
`endif
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (AES_abort) begin
                        en_q      <= 1'b0;
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                        state_q   <= S_DONE;
                    end
`ifdef AES_SEQ_TIMEOUT_EN
                    else if (!seen_q && !AES_data_out_valid &&
                             wd_q == TW'(TIMEOUT - 1)) begin
                        tmo_q   <= 1'b1;
                        en_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
`endif
                    else begin
`ifdef AES_SEQ_TIMEOUT_EN
                        wd_q <= wd_q + 1'b1;
`endif
                        if (!hold_done) hold_q <= hold_q + 1'b1;
                        if (AES_data_out_valid && !seen_q) begin
                            ct_q   <= AES_data_out;
                            ctv_q  <= 1'b1;
                            seen_q <= 1'b1;
                        end
                        if (hold_done && (seen_q || AES_data_out_valid)) begin
                            en_q    <= 1'b0;
                            gap_q   <= '0;
                            state_q <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (AES_abort) begin
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else if (gap_q == GW'(GAP_CYCLES - 2)) begin
                        if (idx_q == num_q - ONE) begin
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_q + ONE;
                            state_q <= S_LOAD;
                        end
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign AES_en        = en_q;
    assign AES_data_in   = din_q;
    assign AES_key_in    = kin_q;
    assign AES_trig      = trig_q;
    assign AES_ct_out    = ct_q;
    assign AES_ct_valid  = ctv_q;
    assign AES_trace_idx = idx_q;
    assign AES_busy      = busy_q;
    assign AES_done      = done_q;
    assign AES_aborted   = aborted_q;

endmodule
